// File: rtl/fft_pkt_fifo.sv
// Single-clock Avalon-ST packet FIFO feeding the FFT core: store-and-forward framing,
// oversize-packet dropping and fill/packet status, with a 2-entry first-word-fall-through output.
module fft_pkt_fifo #(
    parameter int DATA_W      = 14,
    parameter int DEPTH_LOG2  = 10,
    parameter int PACKET_MODE = 1,
    parameter int AF_TH       = (1 << DEPTH_LOG2) - 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   pkt_count,
    output logic                  drop_pulse,
    output logic                  err_pulse,
    output logic [15:0]           drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int MW    = DATA_W + 2;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW-1:0] SPAN_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] AF_TH_P   = PW'(AF_TH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IN_PKT  = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [MW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] ftch_ptr_q, ftch_ptr_d;
    logic [PW-1:0] span;
    logic [1:0]    state_q, state_d;
    logic          rdy_en_q;
    logic          full, push, pop, fetch, pop_eop;
    logic          wr_en, commit_ev, drop_ev, err_ev;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [MW-1:0] rdata;
    logic [MW-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic          vld0_q, vld0_d, vld1_q, vld1_d;
    logic [PW-1:0] fill_q, fill_d, pkt_q, pkt_d;
    logic          af_q, drop_pulse_q, err_pulse_q;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    // rdy_en_q holds in_ready low until the first edge after reset release
    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign in_ready = rdy_en_q & ((state_q == ST_DISCARD) | !full);
    assign push     = in_valid & in_ready;
    assign span     = wr_ptr_q - commit_ptr_q;

    // Write side: framing FSM decides what is stored, committed or rewound
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        state_d      = state_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q[DEPTH_LOG2-1:0];
        commit_ev    = 1'b0;
        drop_ev      = 1'b0;
        err_ev       = 1'b0;
        if (push) begin
            if (PACKET_MODE == 0) begin
                wr_en        = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                commit_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_startofpacket) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (in_endofpacket) begin
                                commit_ptr_d = wr_ptr_q + PTR_ONE;
                                commit_ev    = 1'b1;
                            end else begin
                                state_d = ST_IN_PKT;
                            end
                        end else begin
                            err_ev = 1'b1;
                        end
                    end
                    ST_IN_PKT: begin
                        if (in_startofpacket) begin
                            // restart: the partial packet is overwritten from the commit point
                            err_ev   = 1'b1;
                            wr_en    = 1'b1;
                            wr_addr  = commit_ptr_q[DEPTH_LOG2-1:0];
                            wr_ptr_d = commit_ptr_q + PTR_ONE;
                            if (in_endofpacket) begin
                                commit_ptr_d = commit_ptr_q + PTR_ONE;
                                commit_ev    = 1'b1;
                                state_d      = ST_IDLE;
                            end
                        end else if (in_endofpacket) begin
                            wr_en        = 1'b1;
                            wr_ptr_d     = wr_ptr_q + PTR_ONE;
                            commit_ptr_d = wr_ptr_q + PTR_ONE;
                            commit_ev    = 1'b1;
                            state_d      = ST_IDLE;
                        end else if (span == SPAN_LAST) begin
                            drop_ev  = 1'b1;
                            wr_ptr_d = commit_ptr_q;
                            state_d  = ST_DISCARD;
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                        end
                    end
                    ST_DISCARD: begin
                        if (in_endofpacket) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_en) mem_q[wr_addr] <= {in_endofpacket, in_startofpacket, in_data};
    end

    // Read side: slot0 is the output register, slot1 the skid; only committed entries are fetched
    assign pop     = vld0_q & out_ready;
    assign fetch   = (ftch_ptr_q != commit_ptr_q) & (!vld1_q | pop);
    assign rdata   = mem_q[ftch_ptr_q[DEPTH_LOG2-1:0]];
    assign pop_eop = pop & slot0_q[MW-1] & (PACKET_MODE != 0);

    always_comb begin
        vld0_d     = vld0_q;
        vld1_d     = vld1_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        ftch_ptr_d = ftch_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fetch) ftch_ptr_d = ftch_ptr_q + PTR_ONE;
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (pop) begin
            if (vld1_q) begin
                slot0_d = slot1_q;
                vld1_d  = fetch;
                if (fetch) slot1_d = rdata;
            end else begin
                vld0_d = fetch;
                if (fetch) slot0_d = rdata;
            end
        end else if (fetch) begin
            if (!vld0_q) begin
                vld0_d  = 1'b1;
                slot0_d = rdata;
            end else begin
                vld1_d  = 1'b1;
                slot1_d = rdata;
            end
        end
    end

    // Status: registered from next-state pointers so they lag the transfer by one edge
    always_comb begin
        fill_d = wr_ptr_d - rd_ptr_d;
        pkt_d  = pkt_q;
        if (commit_ev & !pop_eop)      pkt_d = pkt_q + PTR_ONE;
        else if (!commit_ev & pop_eop) pkt_d = pkt_q - PTR_ONE;
        drop_cnt_d = drop_cnt_q;
        if (drop_ev && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            ftch_ptr_q   <= '0;
            state_q      <= ST_IDLE;
            rdy_en_q     <= 1'b0;
            vld0_q       <= 1'b0;
            vld1_q       <= 1'b0;
            slot0_q      <= '0;
            fill_q       <= '0;
            pkt_q        <= '0;
            af_q         <= 1'b0;
            drop_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ftch_ptr_q   <= ftch_ptr_d;
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            vld0_q       <= vld0_d;
            vld1_q       <= vld1_d;
            slot0_q      <= slot0_d;
            fill_q       <= fill_d;
            pkt_q        <= pkt_d;
            af_q         <= fill_d >= AF_TH_P;
            drop_pulse_q <= drop_ev;
            err_pulse_q  <= err_ev;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        slot1_q <= slot1_d;
    end

    assign out_data          = slot0_q[DATA_W-1:0];
    assign out_startofpacket = slot0_q[DATA_W];
    assign out_endofpacket   = slot0_q[DATA_W+1];
    assign out_valid         = vld0_q;
    assign fill_level        = fill_q;
    assign almost_full       = af_q;
    assign pkt_count         = pkt_q;
    assign drop_pulse        = drop_pulse_q;
    assign err_pulse         = err_pulse_q;
    assign drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_fft_pkt_fifo.sv
// Directed bench for fft_pkt_fifo: a streaming instance and a packet-mode instance,
// both DEPTH=16, sharing clock and reset.
module tb_fft_pkt_fifo;
    localparam int DW = 14;
    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s_in_data, s_out_data;
    logic          s_in_valid, s_in_ready, s_in_sop, s_in_eop;
    logic          s_out_valid, s_out_ready, s_out_sop, s_out_eop;
    logic [PW-1:0] s_fill, s_pkt;
    logic          s_af, s_drop_pulse, s_err_pulse;
    logic [15:0]   s_drop_count;

    logic [DW-1:0] p_in_data, p_out_data;
    logic          p_in_valid, p_in_ready, p_sop, p_eop;
    logic          p_out_valid, p_out_ready, p_out_sop, p_out_eop;
    logic [PW-1:0] p_fill, p_pkt;
    logic          p_af, p_drop_pulse, p_err_pulse;
    logic [15:0]   p_drop_count;

    fft_pkt_fifo #(.DATA_W(DW), .DEPTH_LOG2(AW), .PACKET_MODE(0), .AF_TH(12)) u_str (
        .clk_clk(clk), .reset_reset(rst),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_startofpacket(s_in_sop), .in_endofpacket(s_in_eop),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_startofpacket(s_out_sop), .out_endofpacket(s_out_eop),
        .fill_level(s_fill), .almost_full(s_af), .pkt_count(s_pkt),
        .drop_pulse(s_drop_pulse), .err_pulse(s_err_pulse), .drop_count(s_drop_count)
    );

    fft_pkt_fifo #(.DATA_W(DW), .DEPTH_LOG2(AW), .PACKET_MODE(1), .AF_TH(12)) u_pkt (
        .clk_clk(clk), .reset_reset(rst),
        .in_data(p_in_data), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_startofpacket(p_sop), .in_endofpacket(p_eop),
        .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_startofpacket(p_out_sop), .out_endofpacket(p_out_eop),
        .fill_level(p_fill), .almost_full(p_af), .pkt_count(p_pkt),
        .drop_pulse(p_drop_pulse), .err_pulse(p_err_pulse), .drop_count(p_drop_count)
    );

    typedef struct {
        logic          vin;
        logic [DW-1:0] din;
        logic          ordy;
        logic          e_ird;
        logic          e_ovld;
        logic [DW-1:0] e_odata;
        int            e_fill;
        logic          e_af;
    } vec_t;

    vec_t tbl [34];
    int   n_chk = 0;
    int   n_pass = 0;
    int   sent, rcvd, cyc;
    logic push_now, pkt_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic p_push(input logic [DW-1:0] d, input logic s, input logic e);
        p_in_valid = 1'b1;
        p_in_data  = d;
        p_sop      = s;
        p_eop      = e;
        chk("p_push_ready", 32'(p_in_ready), 1);
        tick();
        p_in_valid = 1'b0;
        p_sop      = 1'b0;
        p_eop      = 1'b0;
    endtask

    task automatic p_wait_valid(input string name);
        int n = 0;
        while (!p_out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_wait"}, 32'(p_out_valid), 1);
    endtask

    task automatic p_pop(input string name, input logic [DW-1:0] d, input logic s, input logic e);
        p_out_ready = 1'b1;
        chk({name, "_vld"}, 32'(p_out_valid), 1);
        chk({name, "_data"}, 32'(p_out_data), 32'(d));
        chk({name, "_sop"}, 32'(p_out_sop), 32'(s));
        chk({name, "_eop"}, 32'(p_out_eop), 32'(e));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        s_in_valid = 0; s_in_data = '0; s_in_sop = 0; s_in_eop = 0; s_out_ready = 0;
        p_in_valid = 0; p_in_data = '0; p_sop = 0; p_eop = 0; p_out_ready = 0;

        // Streaming vectors: 16 pushes with the sink stalled, one refused push, then 16 pops
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 14'(i + 1), 1'b0, 1'b1, (i >= 2), (i >= 2) ? 14'(1) : 14'(0), i, (i >= 12)};
        tbl[16] = '{1'b1, 14'h0ABC, 1'b0, 1'b0, 1'b1, 14'h0001, 16, 1'b1};
        tbl[17] = '{1'b1, 14'h0ABC, 1'b1, 1'b0, 1'b1, 14'h0001, 16, 1'b1};
        for (int k = 1; k < 16; k++)
            tbl[17 + k] = '{1'b0, 14'h0, 1'b1, 1'b1, 1'b1, 14'(k + 1), 16 - k, ((16 - k) >= 12)};
        tbl[33] = '{1'b0, 14'h0, 1'b1, 1'b1, 1'b0, 14'h0, 0, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_s_in_ready", 32'(s_in_ready), 0);
        chk("rst_p_in_ready", 32'(p_in_ready), 0);
        chk("rst_p_out_valid", 32'(p_out_valid), 0);
        chk("rst_p_out_data", 32'(p_out_data), 0);
        chk("rst_p_fill", 32'(p_fill), 0);
        chk("rst_p_pkt", 32'(p_pkt), 0);
        chk("rst_p_af", 32'(p_af), 0);
        chk("rst_p_drop_pulse", 32'(p_drop_pulse), 0);
        chk("rst_p_err_pulse", 32'(p_err_pulse), 0);
        chk("rst_p_drop_count", 32'(p_drop_count), 0);
        rst = 1'b0;
        chk("rel_in_ready_pre_edge", 32'(p_in_ready), 0);
        tick();
        chk("rel_s_in_ready", 32'(s_in_ready), 1);
        chk("rel_p_in_ready", 32'(p_in_ready), 1);

        for (int i = 0; i < 34; i++) begin
            s_in_valid  = tbl[i].vin;
            s_in_data   = tbl[i].din;
            s_out_ready = tbl[i].ordy;
            chk("s_in_ready", 32'(s_in_ready), 32'(tbl[i].e_ird));
            chk("s_out_valid", 32'(s_out_valid), 32'(tbl[i].e_ovld));
            if (tbl[i].e_ovld) chk("s_out_data", 32'(s_out_data), 32'(tbl[i].e_odata));
            chk("s_fill", 32'(s_fill), tbl[i].e_fill);
            chk("s_af", 32'(s_af), 32'(tbl[i].e_af));
            tick();
        end
        s_in_valid = 1'b0;
        chk("s_pkt_zero", 32'(s_pkt), 0);
        chk("s_drop_zero", 32'(s_drop_count), 0);

        // 5-beat packet: nothing visible until two cycles after eop
        p_out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            p_push(14'(16'h100 + j), (j == 0), (j == 4));
            chk("pk5_hidden", 32'(p_out_valid), 0);
        end
        chk("pk5_pkt_one", 32'(p_pkt), 1);
        tick();
        for (int j = 0; j < 5; j++) begin
            chk("pk5_pkt_hold", 32'(p_pkt), 1);
            p_pop("pk5", 14'(16'h100 + j), (j == 0), (j == 4));
        end
        chk("pk5_empty", 32'(p_out_valid), 0);
        chk("pk5_pkt_zero", 32'(p_pkt), 0);
        chk("pk5_fill_zero", 32'(p_fill), 0);

        // Restarted packet: partial 3 beats are discarded on the new sop
        p_out_ready = 1'b0;
        p_push(14'h010, 1'b1, 1'b0);
        p_push(14'h011, 1'b0, 1'b0);
        p_push(14'h012, 1'b0, 1'b0);
        chk("err_quiet", 32'(p_err_pulse), 0);
        p_push(14'h200, 1'b1, 1'b0);
        chk("err_pulse_hi", 32'(p_err_pulse), 1);
        p_push(14'h201, 1'b0, 1'b1);
        chk("err_pulse_once", 32'(p_err_pulse), 0);
        chk("err_fill", 32'(p_fill), 2);
        chk("err_pkt", 32'(p_pkt), 1);
        p_wait_valid("err");
        tick();
        chk("err_hold_data", 32'(p_out_data), 32'(14'h200));
        tick();
        chk("err_hold_data2", 32'(p_out_data), 32'(14'h200));
        p_pop("err_a", 14'h200, 1'b1, 1'b0);
        p_pop("err_b", 14'h201, 1'b0, 1'b1);
        chk("err_empty", 32'(p_out_valid), 0);
        chk("err_pkt_zero", 32'(p_pkt), 0);

        // Oversize packet: dropped on beat 16, rest swallowed, next packet intact
        p_out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            p_in_valid = 1'b1;
            p_in_data  = 14'(16'h300 + k);
            p_sop      = (k == 1);
            p_eop      = (k == 20);
            chk("drop_in_ready", 32'(p_in_ready), 1);
            tick();
            chk("drop_pulse", 32'(p_drop_pulse), (k == 16) ? 1 : 0);
            chk("drop_no_out", 32'(p_out_valid), 0);
        end
        p_in_valid = 1'b0; p_sop = 1'b0; p_eop = 1'b0;
        chk("drop_count", 32'(p_drop_count), 1);
        chk("drop_fill", 32'(p_fill), 0);
        p_push(14'h3A0, 1'b1, 1'b0);
        p_push(14'h3A1, 1'b0, 1'b1);
        p_wait_valid("after_drop");
        p_pop("ad_a", 14'h3A0, 1'b1, 1'b0);
        p_pop("ad_b", 14'h3A1, 1'b0, 1'b1);
        chk("ad_empty", 32'(p_out_valid), 0);

        // Pointer wrap: 40 single-beat packets with random back-pressure
        sent = 0; rcvd = 0; cyc = 0; pkt_bad = 1'b0;
        while (rcvd < 40 && cyc < 3000) begin
            p_out_ready = (sent >= 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
            p_in_valid  = (sent < 40);
            p_in_data   = 14'(16'h400 + sent);
            p_sop       = 1'b1;
            p_eop       = 1'b1;
            if (p_out_valid && p_out_ready) begin
                chk("wrap_data", 32'(p_out_data), 32'(16'h400 + rcvd));
                rcvd++;
            end
            if (p_pkt > 5'd16) pkt_bad = 1'b1;
            push_now = p_in_valid & p_in_ready;
            tick();
            if (push_now) sent++;
            cyc++;
        end
        p_in_valid = 1'b0; p_sop = 1'b0; p_eop = 1'b0;
        chk("wrap_all_rcvd", 32'(rcvd), 40);
        chk("wrap_pkt_ok", 32'(pkt_bad), 0);
        tick();
        chk("wrap_fill_zero", 32'(p_fill), 0);
        chk("wrap_pkt_zero", 32'(p_pkt), 0);

        // Reset mid-packet with 8 beats stored (one committed packet plus a partial one)
        p_out_ready = 1'b0;
        p_push(14'h500, 1'b1, 1'b0);
        p_push(14'h501, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) p_push(14'(16'h510 + k), (k == 0), 1'b0);
        chk("mid_fill8", 32'(p_fill), 8);
        chk("mid_pkt1", 32'(p_pkt), 1);
        chk("mid_valid", 32'(p_out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(p_out_valid), 0);
        chk("arst_out_data", 32'(p_out_data), 0);
        chk("arst_out_sop", 32'(p_out_sop), 0);
        chk("arst_fill", 32'(p_fill), 0);
        chk("arst_pkt", 32'(p_pkt), 0);
        chk("arst_drop_count", 32'(p_drop_count), 0);
        chk("arst_in_ready", 32'(p_in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_rel_pre", 32'(p_in_ready), 0);
        tick();
        chk("arst_rel_ready", 32'(p_in_ready), 1);
        chk("arst_rel_empty", 32'(p_out_valid), 0);
        p_push(14'h600, 1'b1, 1'b1);
        p_wait_valid("post_rst");
        p_pop("post_rst", 14'h600, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_pkt_fifo.md
# fft_pkt_fifo

Parametrised single-clock Avalon-ST packet FIFO between the ADC capture path and the FFT core input. It is the successor to the fixed 14-bit dual-clock FFT FIFO, generalised in data width and depth. It adds a store-and-forward packet mode, framing-error recovery, oversize-packet dropping, and fill and packet-count status for the FFT control registers.

## Interface
- DATA_W, 14: data beat width in bits.
- DEPTH_LOG2, 10: storage depth; DEPTH = 2^DEPTH_LOG2 beats.
- PACKET_MODE, 1: 1 = store-and-forward with framing checks; 0 = plain streaming FIFO.
- AF_TH, DEPTH-16: almost_full threshold in beats.
- clk_clk  in  1  sole clock; all logic on rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  sink data.
- in_valid  in  1  sink valid.
- in_ready  out  1  sink ready; a beat transfers when in_valid & in_ready.
- in_startofpacket  in  1  first beat of packet.
- in_endofpacket  in  1  last beat of packet.
- out_data  out  DATA_W  source data.
- out_valid  out  1  source valid.
- out_ready  in  1  source ready; a pop happens when out_valid & out_ready.
- out_startofpacket, out_endofpacket  out  1 each  framing flags, stored with each beat.
- fill_level  out  DEPTH_LOG2+1  beats accepted and not yet popped, including uncommitted beats.
- almost_full  out  1  fill_level >= AF_TH.
- pkt_count  out  DEPTH_LOG2+1  committed packets not yet fully popped (PACKET_MODE=1; 0 otherwise).
- drop_pulse  out  1  one-cycle strobe when a packet is discarded.
- err_pulse  out  1  one-cycle strobe on a framing error.
- drop_count  out  16  number of dropped packets, saturating at 0xFFFF.

## Operation
- Storage is a RAM of DEPTH x (DATA_W+2), holding {eop, sop, data}.
- Pointers wr_ptr, commit_ptr and rd_ptr are each DEPTH_LOG2+1 bits and wrap modulo 2·DEPTH.
- Full: wr_ptr - rd_ptr == DEPTH. Readable: rd_ptr != commit_ptr.
- in_ready = !full, except in DISCARD, where in_ready = 1.
- PACKET_MODE=0:
  - commit_ptr tracks wr_ptr on every accepted beat.
  - sop/eop are stored and replayed unchecked.
  - No drops or errors are flagged.
- PACKET_MODE=1 uses a write FSM with states IDLE, IN_PKT and DISCARD:
  - IDLE, beat with sop & eop: write it, commit, stay in IDLE.
  - IDLE, beat with sop & !eop: write it, go to IN_PKT.
  - IDLE, beat without sop: do not write it; pulse err_pulse.
  - IN_PKT, beat with eop: write it; commit_ptr <= wr_ptr+1; pkt_count +1; go to IDLE.
  - IN_PKT, beat with sop: rewind wr_ptr to commit_ptr; pulse err_pulse; write the new beat as a packet start (IN_PKT, or commit at once if it also has eop).
  - IN_PKT, uncommitted span wr_ptr - commit_ptr reaches DEPTH without eop: rewind wr_ptr to commit_ptr; pulse drop_pulse; drop_count +1; go to DISCARD.
  - DISCARD: accept and discard beats up to and including eop, then go to IDLE.
- Output stage:
  - A 2-entry prefetch (RAM read plus output register/skid) presents first-word-fall-through data.
  - Sustains 1 beat/cycle while out_ready = 1.
  - Only committed entries are ever prefetched.
- pkt_count:
  - +1 on commit, -1 on a pop of an eop beat.
  - Simultaneous commit and eop pop: unchanged.
- fill_level:
  - +1 per accepted, written beat; -1 per pop.
  - A rewind subtracts the rewound span in the same cycle.

## Timing
- Reset values:
  - in_ready = 0 while reset_reset = 1; in_ready = 1 on the first edge after release.
  - out_valid, out_startofpacket, out_endofpacket = 0; out_data = 0.
  - fill_level, pkt_count, drop_count = 0; almost_full, drop_pulse, err_pulse = 0.
  - Pointers = 0; FSM in IDLE.
- Latency:
  - Streaming: a beat accepted in cycle N is on out_valid in cycle N+2.
  - Packet mode: an eop accepted in cycle N makes that packet's sop beat valid in cycle N+2.
- out_data and flags hold stable while out_valid & !out_ready.
- Simultaneous push and pop while full:
  - in_ready is 0 in that cycle (it depends on registered state only); no combinational path from out_ready to in_ready.
- Status outputs are registered and update one cycle after the causing transfer. drop_pulse and err_pulse are high exactly one cycle.
- Reset asserted mid-packet: all state clears immediately; partial and committed data are lost.

## Test plan
- PACKET_MODE=0, DATA_W=14, DEPTH_LOG2=4: push 16 beats 0x0001..0x0010 with out_ready = 0 -> in_ready = 0 after the 16th beat and fill_level = 16; then out_ready = 1 -> 16 pops in order, one per cycle.
- PACKET_MODE=1: push a 5-beat packet 0x100..0x104 -> out_valid stays 0 until 2 cycles after eop; then 0x100 (sop) through 0x104 (eop) pop back-to-back; pkt_count 1 -> 0.
- PACKET_MODE=1: 3 beats, then a new sop and a 2-beat packet 0x200/0x201 -> err_pulse once; only 0x200/0x201 appear at the output; fill_level = 2 before popping.
- PACKET_MODE=1, DEPTH_LOG2=4: a 20-beat packet -> drop_pulse once at beat 16; beats 17..20 accepted with in_ready = 1; drop_count = 1; no output; a following 2-beat packet passes intact.
- Pointer wrap: 40 single-beat packets through DEPTH=16 with random out_ready -> data in order, pkt_count never underflows, fill_level ends at 0.
- Assert reset_reset mid-packet while 8 beats are stored -> all outputs return to reset values asynchronously; in_ready returns 1 one edge after release.
